// File: rtl/msg_framer.sv
// AXI-Stream transmit framer: takes a beat-count command, forwards that many
// beats with a registered output stage and marks the final beat with m_tlast.
module msg_framer #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_COUNT_BITS = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      len_valid,
    output logic                      len_ready,
    input  logic [NUM_COUNT_BITS-1:0] len_in,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    input  logic [DATA_WIDTH-1:0]     s_tdata,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic [DATA_WIDTH-1:0]     m_tdata,
    output logic                      m_tlast,
    output logic [NUM_COUNT_BITS-1:0] beat_count,
    output logic                      busy,
    output logic                      len_err
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [NUM_COUNT_BITS-1:0]   target_q, target_d;
    logic [NUM_COUNT_BITS-1:0]   count_q, count_d;
    logic [NUM_COUNT_BITS-1:0]   count_inc;
    logic                        mvalid_q, mvalid_d;
    logic [DATA_WIDTH-1:0]       mdata_q, mdata_d;
    logic                        mlast_q, mlast_d;
    logic                        lenerr_q, lenerr_d;
    logic                        len_hs;
    logic                        s_hs;

    assign len_ready = (state_q == IDLE);
    assign s_tready  = (state_q == STREAM) && (!mvalid_q || m_tready);
    assign len_hs    = len_valid && len_ready;
    assign s_hs      = s_tvalid && s_tready;
    // count never reaches target before the last beat, so the increment cannot wrap
    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        count_d  = count_q;
        mvalid_d = mvalid_q;
        mdata_d  = mdata_q;
        mlast_d  = mlast_q;
        lenerr_d = 1'b0;

        if (clear) begin
            state_d  = IDLE;
            mvalid_d = 1'b0;
            mlast_d  = 1'b0;
            count_d  = '0;
        end else begin
            if (m_tready) begin
                mvalid_d = 1'b0;
                mlast_d  = 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (len_hs) begin
                        if (len_in == '0) begin
                            lenerr_d = 1'b1;
                        end else begin
                            target_d = len_in;
                            count_d  = '0;
                            state_d  = STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (s_hs) begin
                        mdata_d  = s_tdata;
                        mvalid_d = 1'b1;
                        mlast_d  = (count_inc == target_q);
                        count_d  = count_inc;
                        if (count_inc == target_q) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            target_q <= '0;
            count_q  <= '0;
            mvalid_q <= 1'b0;
            mdata_q  <= '0;
            mlast_q  <= 1'b0;
            lenerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            count_q  <= count_d;
            mvalid_q <= mvalid_d;
            mdata_q  <= mdata_d;
            mlast_q  <= mlast_d;
            lenerr_q <= lenerr_d;
        end
    end

    assign m_tvalid   = mvalid_q;
    assign m_tdata    = mdata_q;
    assign m_tlast    = mlast_q;
    assign beat_count = count_q;
    assign busy       = (state_q == STREAM) || mvalid_q;
    assign len_err    = lenerr_q;

endmodule

// File: tb/tb_msg_framer.sv
// Directed bench for msg_framer: framing, back-pressure, zero length, clear
// and asynchronous reset, with hand-computed expectations.
module tb_msg_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        len_valid;
    logic        len_ready;
    logic [15:0] len_in;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] s_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic [15:0] beat_count;
    logic        busy;
    logic        len_err;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    msg_framer #(
        .DATA_WIDTH     (32),
        .NUM_COUNT_BITS (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .len_valid  (len_valid),
        .len_ready  (len_ready),
        .len_in     (len_in),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tdata    (s_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .beat_count (beat_count),
        .busy       (busy),
        .len_err    (len_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] d,
                             input logic l, input logic [15:0] bc);
        check({tag, ".m_tvalid"}, {31'd0, m_tvalid}, {31'd0, v});
        if (v) check({tag, ".m_tdata"}, m_tdata, d);
        check({tag, ".m_tlast"}, {31'd0, m_tlast}, {31'd0, l});
        check({tag, ".beat_count"}, {16'd0, beat_count}, {16'd0, bc});
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; len_valid = 1'b0; len_in = '0;
        s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;

        // ---- reset ----
        #1 rst = 1'b0;
        #1;
        check_out("rst", 1'b0, 32'h0, 1'b0, 16'd0);
        check("rst.m_tdata", m_tdata, 32'h0);
        check("rst.len_err", {31'd0, len_err}, 32'd0);
        check("rst.len_ready", {31'd0, len_ready}, 32'd1);
        check("rst.busy", {31'd0, busy}, 32'd0);
        tick(); tick();
        #4 rst = 1'b1;

        // ---- 1: 4-beat message, full throughput ----
        len_valid = 1'b1; len_in = 16'd4;
        tick();
        check("t1.busy", {31'd0, busy}, 32'd1);
        check("t1.len_ready", {31'd0, len_ready}, 32'd0);
        len_valid = 1'b0; s_tvalid = 1'b1; m_tready = 1'b1; s_tdata = 32'hD000_0000;
        #1 check("t1.s_tready", {31'd0, s_tready}, 32'd1);
        tick(); check_out("t1.b0", 1'b1, 32'hD000_0000, 1'b0, 16'd1);
        s_tdata = 32'hD000_0001;
        tick(); check_out("t1.b1", 1'b1, 32'hD000_0001, 1'b0, 16'd2);
        s_tdata = 32'hD000_0002;
        tick(); check_out("t1.b2", 1'b1, 32'hD000_0002, 1'b0, 16'd3);
        s_tdata = 32'hD000_0003;
        tick(); check_out("t1.b3", 1'b1, 32'hD000_0003, 1'b1, 16'd4);
        check("t1.s_tready_idle", {31'd0, s_tready}, 32'd0);
        s_tvalid = 1'b0;
        tick(); check_out("t1.drain", 1'b0, 32'h0, 1'b0, 16'd4);
        check("t1.busy_end", {31'd0, busy}, 32'd0);

        // ---- 2: 3-beat message, m_tready toggling ----
        len_valid = 1'b1; len_in = 16'd3;
        tick();
        len_valid = 1'b0; s_tvalid = 1'b1; s_tdata = 32'hA000_0000; m_tready = 1'b1;
        tick(); check_out("t2.a0", 1'b1, 32'hA000_0000, 1'b0, 16'd1);
        m_tready = 1'b0; s_tdata = 32'hA000_0001;
        #1 check("t2.stall_s_tready", {31'd0, s_tready}, 32'd0);
        tick(); check_out("t2.a0_hold", 1'b1, 32'hA000_0000, 1'b0, 16'd1);
        m_tready = 1'b1;
        #1 check("t2.go_s_tready", {31'd0, s_tready}, 32'd1);
        tick(); check_out("t2.a1", 1'b1, 32'hA000_0001, 1'b0, 16'd2);
        m_tready = 1'b0; s_tdata = 32'hA000_0002;
        #1 check("t2.stall2_s_tready", {31'd0, s_tready}, 32'd0);
        tick(); check_out("t2.a1_hold", 1'b1, 32'hA000_0001, 1'b0, 16'd2);
        m_tready = 1'b1;
        tick(); check_out("t2.a2", 1'b1, 32'hA000_0002, 1'b1, 16'd3);
        m_tready = 1'b0;
        tick(); check_out("t2.a2_hold", 1'b1, 32'hA000_0002, 1'b1, 16'd3);
        check("t2.pending_busy", {31'd0, busy}, 32'd1);
        check("t2.pending_len_ready", {31'd0, len_ready}, 32'd1);
        check("t2.idle_s_tready", {31'd0, s_tready}, 32'd0);
        m_tready = 1'b1; s_tvalid = 1'b0;
        tick(); check_out("t2.drain", 1'b0, 32'h0, 1'b0, 16'd3);

        // ---- 3: zero-length command ----
        len_valid = 1'b1; len_in = 16'd0;
        tick();
        check("t3.len_err", {31'd0, len_err}, 32'd1);
        check("t3.len_ready", {31'd0, len_ready}, 32'd1);
        check("t3.s_tready", {31'd0, s_tready}, 32'd0);
        check("t3.m_tvalid", {31'd0, m_tvalid}, 32'd0);
        len_valid = 1'b0;
        tick();
        check("t3.len_err_clr", {31'd0, len_err}, 32'd0);
        check("t3.busy", {31'd0, busy}, 32'd0);

        // ---- 4: 1-beat message then back-to-back 2-beat message ----
        len_valid = 1'b1; len_in = 16'd1;
        tick();
        len_valid = 1'b0; s_tvalid = 1'b1; s_tdata = 32'hB000_0000;
        tick(); check_out("t4.b0", 1'b1, 32'hB000_0000, 1'b1, 16'd1);
        check("t4.len_ready", {31'd0, len_ready}, 32'd1);
        len_valid = 1'b1; len_in = 16'd2; s_tdata = 32'hC000_0000;
        tick(); check_out("t4.len2", 1'b0, 32'h0, 1'b0, 16'd0);
        check("t4.s_tready", {31'd0, s_tready}, 32'd1);
        len_valid = 1'b0;
        tick(); check_out("t4.c0", 1'b1, 32'hC000_0000, 1'b0, 16'd1);
        s_tdata = 32'hC000_0001;
        tick(); check_out("t4.c1", 1'b1, 32'hC000_0001, 1'b1, 16'd2);
        s_tvalid = 1'b0;
        tick(); check_out("t4.drain", 1'b0, 32'h0, 1'b0, 16'd2);

        // ---- 5: clear after beat 2 of 5 ----
        len_valid = 1'b1; len_in = 16'd5;
        tick();
        len_valid = 1'b0; s_tvalid = 1'b1; s_tdata = 32'hE000_0000;
        tick();
        s_tdata = 32'hE000_0001;
        tick(); check_out("t5.e1", 1'b1, 32'hE000_0001, 1'b0, 16'd2);
        clear = 1'b1; m_tready = 1'b0; s_tdata = 32'hE000_0002;
        tick(); check_out("t5.clear", 1'b0, 32'h0, 1'b0, 16'd0);
        check("t5.len_ready", {31'd0, len_ready}, 32'd1);
        check("t5.busy", {31'd0, busy}, 32'd0);
        clear = 1'b0; s_tvalid = 1'b0; m_tready = 1'b1;
        tick(); check_out("t5.after", 1'b0, 32'h0, 1'b0, 16'd0);

        // ---- 6: async reset mid-message, then clean 2-beat message ----
        len_valid = 1'b1; len_in = 16'd3;
        tick();
        len_valid = 1'b0; s_tvalid = 1'b1; s_tdata = 32'h6000_0000;
        tick(); check_out("t6.pre", 1'b1, 32'h6000_0000, 1'b0, 16'd1);
        #2 rst = 1'b0;
        #1;
        check_out("t6.rst", 1'b0, 32'h0, 1'b0, 16'd0);
        check("t6.rst_m_tdata", m_tdata, 32'h0);
        check("t6.rst_busy", {31'd0, busy}, 32'd0);
        check("t6.rst_len_ready", {31'd0, len_ready}, 32'd1);
        #1 rst = 1'b1;
        s_tvalid = 1'b0;
        len_valid = 1'b1; len_in = 16'd2;
        tick();
        len_valid = 1'b0; s_tvalid = 1'b1; s_tdata = 32'hF000_0000;
        tick(); check_out("t6.f0", 1'b1, 32'hF000_0000, 1'b0, 16'd1);
        s_tdata = 32'hF000_0001;
        tick(); check_out("t6.f1", 1'b1, 32'hF000_0001, 1'b1, 16'd2);
        s_tvalid = 1'b0;
        tick(); check_out("t6.drain", 1'b0, 32'h0, 1'b0, 16'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
